alu_seq: RTL and testbench

Registered, handshaked execute-stage ALU, successor to the single-cycle datapath ALU. Parametrised in data width; implements the full RV32I integer op set plus equality flag, with an optional iterative multiply/divide unit. Sits between decode/operand-mux and writeback. Single-cycle ops stream one per clock; iterative ops stall issue via `Ready_out`.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_seq_if.sv | 35 +++
 rtl/alu_muldiv_iter.sv | 103 ++++++++++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the alu_seq execute stage.
//                It holds the op-code enum, the FSM state enum, the
//                multiply/divide sub-op enum and the default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_PASSB = 4'd10,
    OP_UNDEF = 4'd11,
    OP_MUL   = 4'd12,
    OP_MULHU = 4'd13,
    OP_DIVU  = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } alu_state_e;

  // Low two bits of the op codes 12..15 map directly onto this enum.
  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } muldiv_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Issue/result bundle between decode/operand-mux and the
//                alu_seq execute stage.
//  Ports       : Start_in, ALUop1_in, ALUop2_in, ALUctrl_in  (issue side)
//                Ready_out, Valid_out, Result_out, EQ_out, Illegal_out
//  Modports    : master = issuing stage, slave = ALU
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
);
  logic                  Start_in;
  logic [DATA_WIDTH-1:0] ALUop1_in;
  logic [DATA_WIDTH-1:0] ALUop2_in;
  logic [CTRL_WIDTH-1:0] ALUctrl_in;
  logic                  Ready_out;
  logic                  Valid_out;
  logic [DATA_WIDTH-1:0] Result_out;
  logic                  EQ_out;
  logic                  Illegal_out;

  modport master (
    output Start_in, ALUop1_in, ALUop2_in, ALUctrl_in,
    input  Ready_out, Valid_out, Result_out, EQ_out, Illegal_out
  );

  modport slave (
    input  Start_in, ALUop1_in, ALUop2_in, ALUctrl_in,
    output Ready_out, Valid_out, Result_out, EQ_out, Illegal_out
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Iterative radix-2 multiply (shift-add) / divide (restoring)
//                datapath with its own step counter. One step per clock,
//                DATA_WIDTH steps per operation.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                start_i        load operands, counter := DATA_WIDTH
//                op_i           MUL / MULHU / DIVU / REMU
//                a_i, b_i       operands (captured on start_i)
//                done_o         high in the cycle of the last step
//                result_o       final result, valid while done_o=1
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  muldiv_op_e            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  // hi holds partial product upper half / partial remainder,
  // lo holds multiplier bits still to consume / quotient being built.
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  muldiv_op_e            op_q, op_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   w_sum, w_trial, w_diff;
  logic                  w_is_mul;

  always_comb begin
    w_is_mul = (op_q == MD_MUL) || (op_q == MD_MULHU);
    w_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    w_trial  = {hi_q, lo_q[DATA_WIDTH-1]};
    w_diff   = w_trial - {1'b0, b_q};

    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;

    if (start_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      op_d  = op_i;
      cnt_d = CW'(DATA_WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (w_is_mul) begin
        // Add multiplicand if the current multiplier bit is set, then
        // shift the whole {hi,lo} pair right; the carry enters hi's MSB.
        hi_d = w_sum[DATA_WIDTH:1];
        lo_d = {w_sum[0], lo_q[DATA_WIDTH-1:1]};
      end else if (!w_diff[DATA_WIDTH]) begin
        // No borrow: divisor fits, keep the difference, quotient bit 1.
        hi_d = w_diff[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_d = w_trial[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // The result is taken from the next-state values so that the owner can
  // register it on the same edge the counter goes 1 -> 0.
  always_comb begin
    done_o = (cnt_q == CW'(1)) && !start_i;
    case (op_q)
      MD_MULHU, MD_REMU: result_o = hi_d;
      default:           result_o = lo_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      op_q  <= MD_MUL;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered, handshaked execute-stage ALU. Single-cycle ops
//                stream one per clock; MUL/MULHU/DIVU/REMU run on an
//                iterative unit and hold Ready_out low while busy.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                alu_bus    alu_seq_if.slave (issue + result signals)
//  Config      : ALU_MULDIV_EN  define to build the iterative mul/div unit;
//                               otherwise codes 12..15 report Illegal_out.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_W,
  parameter int CTRL_WIDTH = ALU_CTRL_W
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave alu_bus
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  eq_q, eq_d;
  logic                  eq_pend_q, eq_pend_d;
  logic                  illegal_q, illegal_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] w_a, w_b, w_sc_result, w_md_result;
  logic [SHW-1:0]        w_shamt;
  alu_op_e               w_op;
  logic                  w_ctrl_hi_ok, w_ready, w_accept, w_eq;
  logic                  w_illegal, w_is_iter, w_md_done;

  assign w_a     = alu_bus.ALUop1_in;
  assign w_b     = alu_bus.ALUop2_in;
  assign w_shamt = w_b[SHW-1:0];
  assign w_op    = alu_op_e'(alu_bus.ALUctrl_in[ALU_CTRL_W-1:0]);
  assign w_eq    = (w_a == w_b);

  // Op-select bits above the defined 4-bit code make the op undefined.
  generate
    if (CTRL_WIDTH > ALU_CTRL_W) begin : g_ctrl_hi
      assign w_ctrl_hi_ok = ~|alu_bus.ALUctrl_in[CTRL_WIDTH-1:ALU_CTRL_W];
    end else begin : g_ctrl_exact
      assign w_ctrl_hi_ok = 1'b1;
    end
  endgenerate

  assign w_ready  = (state_q == ST_IDLE);
  assign w_accept = alu_bus.Start_in && w_ready;

  // Single-cycle result and op classification for the presented code.
  always_comb begin
    w_sc_result = '0;
    w_illegal   = 1'b0;
    w_is_iter   = 1'b0;
    case (w_op)
      OP_ADD:   w_sc_result = w_a + w_b;
      OP_SUB:   w_sc_result = w_a - w_b;
      OP_SLL:   w_sc_result = w_a << w_shamt;
      OP_SLT:   w_sc_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLTU:  w_sc_result = {{(DATA_WIDTH-1){1'b0}}, (w_a < w_b)};
      OP_XOR:   w_sc_result = w_a ^ w_b;
      OP_SRL:   w_sc_result = w_a >> w_shamt;
      OP_SRA:   w_sc_result = $unsigned($signed(w_a) >>> w_shamt);
      OP_OR:    w_sc_result = w_a | w_b;
      OP_AND:   w_sc_result = w_a & w_b;
      OP_PASSB: w_sc_result = w_b;
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_MULHU: w_is_iter = 1'b1;
      // Division by zero has a fixed answer, so it never occupies the unit.
      OP_DIVU: begin
        if (w_b == '0) w_sc_result = '1;
        else           w_is_iter   = 1'b1;
      end
      OP_REMU: begin
        if (w_b == '0) w_sc_result = w_a;
        else           w_is_iter   = 1'b1;
      end
`endif
      default:  w_illegal = 1'b1;
    endcase
    if (!w_ctrl_hi_ok) begin
      w_sc_result = '0;
      w_illegal   = 1'b1;
      w_is_iter   = 1'b0;
    end
  end

`ifdef ALU_MULDIV_EN
  logic w_md_start;
  assign w_md_start = w_accept && w_is_iter;

  alu_muldiv_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_md_start),
    .op_i     (muldiv_op_e'(w_op[1:0])),
    .a_i      (w_a),
    .b_i      (w_b),
    .done_o   (w_md_done),
    .result_o (w_md_result)
  );
`else
  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
`endif

  // Next-state and output-register logic. Results and flags are held
  // between Valid_out pulses; the equality of an iterative op's operands
  // is parked until that op completes.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    eq_d      = eq_q;
    eq_pend_d = eq_pend_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_iter) begin
            state_d   = ST_ITER;
            eq_pend_d = w_eq;
          end else begin
            result_d  = w_sc_result;
            eq_d      = w_eq;
            illegal_d = w_illegal;
            valid_d   = 1'b1;
          end
        end
      end
      ST_ITER: begin
        if (w_md_done) begin
          state_d   = ST_IDLE;
          result_d  = w_md_result;
          eq_d      = eq_pend_q;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      eq_q      <= 1'b0;
      eq_pend_q <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      eq_q      <= eq_d;
      eq_pend_q <= eq_pend_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign alu_bus.Ready_out   = w_ready;
  assign alu_bus.Valid_out   = valid_q;
  assign alu_bus.Result_out  = result_q;
  assign alu_bus.EQ_out      = eq_q;
  assign alu_bus.Illegal_out = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq: directed cases followed by
//                random ops compared against an arithmetic reference model.
//                Follows ALU_MULDIV_EN the same way the design does.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) bus ();

  alu_seq #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_bus (bus)
  );

`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on 64-bit values.
  function automatic void ref_model(input int op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit ill, output bit iter);
    logic [63:0] ext;
    logic [63:0] prod;
    int          sh;
    sh   = int'(b % 32);
    r    = 32'h0;
    ill  = 1'b0;
    iter = 1'b0;
    prod = 64'(a) * 64'(b);
    case (op)
      0:  r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      1:  r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      2:  r = 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      3:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4:  r = (a < b) ? 32'd1 : 32'd0;
      5:  r = a ^ b;
      6:  r = 32'(64'(a) / (64'd1 << sh));
      7:  begin
            ext = a[31] ? (64'hFFFF_FFFF_0000_0000 | 64'(a)) : 64'(a);
            ext = ext >> sh;
            r   = ext[31:0];
          end
      8:  r = a | b;
      9:  r = a & b;
      10: r = b;
      12: if (MD_EN) begin r = prod[31:0];  iter = 1'b1; end else ill = 1'b1;
      13: if (MD_EN) begin r = prod[63:32]; iter = 1'b1; end else ill = 1'b1;
      14: if (MD_EN) begin
            r    = (b == 0) ? 32'hFFFF_FFFF : a / b;
            iter = (b != 0);
          end else ill = 1'b1;
      15: if (MD_EN) begin
            r    = (b == 0) ? a : a % b;
            iter = (b != 0);
          end else ill = 1'b1;
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op, keep poking Start_in during any stall, wait for the
  // result and check it together with latency and the flags.
  task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r;
    bit          exp_ill, exp_iter;
    int          k;
    int          ready_hi;
    ref_model(op, a, b, exp_r, exp_ill, exp_iter);
    bus.Start_in   = 1'b1;
    bus.ALUctrl_in = 4'(op);
    bus.ALUop1_in  = a;
    bus.ALUop2_in  = b;
    tick();
    // Inputs change during the stall; none of it may be accepted or leak in.
    bus.ALUctrl_in = 4'd0;
    bus.ALUop1_in  = $urandom;
    bus.ALUop2_in  = $urandom;
    k        = 1;
    ready_hi = 0;
    while (!bus.Valid_out && k < 100) begin
      if (bus.Ready_out) ready_hi++;
      tick();
      k++;
    end
    bus.Start_in = 1'b0;
    check({tag, "_valid"},   64'(bus.Valid_out), 64'd1);
    check({tag, "_latency"}, 64'(k), exp_iter ? 64'(W + 1) : 64'd1);
    check({tag, "_stall"},   64'(ready_hi), 64'd0);
    check({tag, "_result"},  64'(bus.Result_out), 64'(exp_r));
    check({tag, "_illegal"}, 64'(bus.Illegal_out), 64'(exp_ill));
    check({tag, "_eq"},      64'(bus.EQ_out), 64'(a == b));
    check({tag, "_ready"},   64'(bus.Ready_out), 64'd1);
    tick();
    check({tag, "_pulse"},   64'(bus.Valid_out), 64'd0);
  endtask

  initial begin
    int nvalid;
    int op;
    logic [31:0] ra, rb;

    bus.Start_in   = 1'b0;
    bus.ALUctrl_in = 4'd0;
    bus.ALUop1_in  = 32'd0;
    bus.ALUop2_in  = 32'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready",   64'(bus.Ready_out),   64'd1);
    check("rst_valid",   64'(bus.Valid_out),   64'd0);
    check("rst_result",  64'(bus.Result_out),  64'd0);
    check("rst_eq",      64'(bus.EQ_out),      64'd0);
    check("rst_illegal", 64'(bus.Illegal_out), 64'd0);

    run_op("add_wrap", 0, 32'hFFFF_FFFF, 32'h1);

    // Back-to-back single-cycle ops: SRA then SLTU.
    bus.Start_in = 1'b1; bus.ALUctrl_in = 4'd7;
    bus.ALUop1_in = 32'h8000_0000; bus.ALUop2_in = 32'h24;
    tick();
    check("b2b_sra_valid", 64'(bus.Valid_out),  64'd1);
    check("b2b_sra",       64'(bus.Result_out), 64'hF800_0000);
    check("b2b_ready",     64'(bus.Ready_out),  64'd1);
    bus.ALUctrl_in = 4'd4; bus.ALUop1_in = 32'h1; bus.ALUop2_in = 32'hFFFF_FFFF;
    tick();
    bus.Start_in = 1'b0;
    check("b2b_sltu_valid", 64'(bus.Valid_out),  64'd1);
    check("b2b_sltu",       64'(bus.Result_out), 64'd1);
    tick();
    check("b2b_end", 64'(bus.Valid_out), 64'd0);

    run_op("mul",     12, 32'h0001_0000, 32'h0001_0000);
    run_op("mulhu",   13, 32'h0001_0000, 32'h0001_0000);
    run_op("divu",    14, 32'd100, 32'd7);
    run_op("remu",    15, 32'd100, 32'd7);
    run_op("divu_z",  14, 32'd5, 32'd0);
    run_op("remu_z",  15, 32'd5, 32'd0);
    run_op("undef11", 11, 32'd3, 32'd3);
    run_op("slt_neg",  3, 32'hFFFF_FFFF, 32'd1);
    run_op("sll_big",  2, 32'h0000_0001, 32'hFFFF_FFFF);

    // Reset ten cycles into a divide abandons it.
    bus.Start_in = 1'b1; bus.ALUctrl_in = 4'd14;
    bus.ALUop1_in = 32'd1000; bus.ALUop2_in = 32'd3;
    tick();
    bus.Start_in = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 64'(bus.Ready_out), 64'd1);
    check("abort_valid", 64'(bus.Valid_out), 64'd0);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Valid_out) nvalid++;
      tick();
    end
    check("abort_no_valid", 64'(nvalid), 64'd0);
    run_op("add_after_rst", 0, 32'd2, 32'd3);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 9));
        1:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
